// File: rtl/bpb_assoc_pkg.sv
// Shared types and helpers for the set-associative branch prediction buffer.
// Entry tags are stored BPB_TAG_W wide; narrower TAG_W values are zero-extended.
package bpb_assoc_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t destpc;
        logic  taken;
    } bpb_result_t;

    localparam int         BPB_SETS     = 16;
    localparam int         BPB_IDX_W    = $clog2(BPB_SETS);
    localparam int         BPB_TAG_W    = 10;
    localparam logic [1:0] BPB_CTR_INIT = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [BPB_TAG_W-1:0] tag;
        word_t                target;
        logic [1:0]           ctr;
    } bpb_entry_t;

    // Two-bit saturating direction counter step.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bpb_assoc_set.sv
// One set of the prediction buffer: WAYS entries, the round-robin victim pointer,
// per-port tag compare and the commit update/allocate path.
module bpb_assoc_set
    import bpb_assoc_pkg::*;
#(
    parameter int         WAYS     = 2,
    parameter int         PORTS    = 2,
    parameter logic [1:0] CTR_INIT = BPB_CTR_INIT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [PORTS-1:0][BPB_TAG_W-1:0]   lookup_tag,
    output logic [PORTS-1:0]                  lookup_hit,
    output bpb_result_t [PORTS-1:0]           lookup_result,
    input  logic                              commit_en,
    input  logic [BPB_TAG_W-1:0]              commit_tag,
    input  bpb_result_t                       commit_result
);

    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    bpb_entry_t             entries [WAYS];
    logic [WAY_W-1:0]       rr_ptr;

    logic [PORTS-1:0][WAYS-1:0] match;
    logic [WAYS-1:0]            c_match;
    logic                       c_hit;
    logic [WAY_W-1:0]           c_way;
    logic                       inv_found;
    logic [WAY_W-1:0]           inv_way;
    logic [WAY_W-1:0]           victim;

    // Lookup: descending scan so the lowest matching way is the one reported.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            lookup_hit[p]    = 1'b0;
            lookup_result[p] = '0;
            for (int w = 0; w < WAYS; w++) begin
                match[p][w] = entries[w].valid && (entries[w].tag == lookup_tag[p]);
            end
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (match[p][w]) begin
                    lookup_hit[p]    = 1'b1;
                    lookup_result[p] = {entries[w].target, entries[w].ctr[1]};
                end
            end
        end
    end

    always_comb begin
        c_match   = '0;
        c_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            c_match[w] = entries[w].valid && (entries[w].tag == commit_tag);
            if (c_match[w]) begin
                c_way = WAY_W'(w);
            end
            if (!entries[w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        c_hit  = |c_match;
        victim = inv_found ? inv_way : rr_ptr;
    end

    // Commit: train on hit, allocate on taken miss; the pointer only moves on eviction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) begin
                entries[w].valid <= 1'b0;
                entries[w].ctr   <= 2'b00;
            end
            rr_ptr <= '0;
        end else if (commit_en) begin
            if (c_hit) begin
                entries[c_way].ctr <= ctr_next(entries[c_way].ctr, commit_result.taken);
                if (commit_result.taken) begin
                    entries[c_way].target <= commit_result.destpc;
                end
            end else if (commit_result.taken) begin
                entries[victim] <= {1'b1, commit_tag, commit_result.destpc, CTR_INIT};
                if (!inv_found && (WAYS > 1)) begin
                    rr_ptr <= rr_ptr + 1'b1;
                end
            end
        end
    end

    for (genvar gp = 0; gp < PORTS; gp++) begin : g_chk
        a_single_hit: assert property (@(posedge clk) disable iff (reset) $onehot0(match[gp]));
    end

endmodule

// File: rtl/bpb_assoc.sv
// Set-associative branch prediction buffer: PORTS registered lookups per cycle
// and one commit port for training and allocation.
module bpb_assoc
    import bpb_assoc_pkg::*;
#(
    parameter int         SETS     = BPB_SETS,
    parameter int         WAYS     = 2,
    parameter int         PORTS    = 2,
    parameter int         TAG_W    = BPB_TAG_W,
    parameter logic [1:0] CTR_INIT = BPB_CTR_INIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  word_t [PORTS-1:0]        pc_predict,
    output logic [PORTS-1:0]         hit,
    output bpb_result_t [PORTS-1:0]  destpc_predict,
    input  word_t                    pc_commit,
    input  logic                     wen,
    input  bpb_result_t              destpc_commit
);

    localparam int IDX_W = $clog2(SETS);

    function automatic logic [IDX_W-1:0] pc_idx(input word_t pc);
        return pc[2 +: IDX_W];
    endfunction

    function automatic logic [BPB_TAG_W-1:0] pc_tag(input word_t pc);
        logic [BPB_TAG_W-1:0] t;
        t            = '0;
        t[TAG_W-1:0] = pc[2+IDX_W +: TAG_W];
        return t;
    endfunction

    logic [PORTS-1:0][BPB_TAG_W-1:0] lk_tag;
    logic [PORTS-1:0]                set_hit [SETS];
    bpb_result_t [PORTS-1:0]         set_res [SETS];
    logic [SETS-1:0]                 set_wen;
    logic [PORTS-1:0]                vld_p0;
    bpb_result_t [PORTS-1:0]         res_p0;
    logic [PORTS-1:0]                vld_p1;
    bpb_result_t [PORTS-1:0]         res_p1;

    wire unused_pc_bits = ^{pc_commit, pc_predict};

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            lk_tag[p] = pc_tag(pc_predict[p]);
        end
        for (int s = 0; s < SETS; s++) begin
            set_wen[s] = wen && (pc_idx(pc_commit) == IDX_W'(s));
        end
    end

    for (genvar gs = 0; gs < SETS; gs++) begin : g_set
        bpb_assoc_set #(
            .WAYS     (WAYS),
            .PORTS    (PORTS),
            .CTR_INIT (CTR_INIT)
        ) u_set (
            .clk           (clk),
            .reset         (reset),
            .lookup_tag    (lk_tag),
            .lookup_hit    (set_hit[gs]),
            .lookup_result (set_res[gs]),
            .commit_en     (set_wen[gs]),
            .commit_tag    (pc_tag(pc_commit)),
            .commit_result (destpc_commit)
        );
    end

    // Stage p0: select each port's set by index.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            vld_p0[p] = set_hit[pc_idx(pc_predict[p])][p];
            res_p0[p] = set_res[pc_idx(pc_predict[p])][p];
        end
    end

    // Stage p1: output registers, frozen while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= '0;
            res_p1 <= '0;
        end else if (!stall) begin
            vld_p1 <= vld_p0;
            res_p1 <= res_p0;
        end
    end

    assign hit            = vld_p1;
    assign destpc_predict = res_p1;

endmodule

// File: tb/tb_bpb_assoc.sv
// Directed bench for bpb_assoc: table of single-edge vectors plus a stall/reset sequence.
module tb_bpb_assoc;
    import bpb_assoc_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall;
    word_t [1:0]        pc_predict;
    logic [1:0]         hit;
    bpb_result_t [1:0]  destpc_predict;
    word_t              pc_commit;
    logic               wen;
    bpb_result_t        destpc_commit;

    int checks = 0;
    int errors = 0;

    localparam word_t A  = 32'h8000_0100;
    localparam word_t A4 = 32'h8000_0104;
    localparam word_t B  = 32'h8000_0140;
    localparam word_t C  = 32'h8000_0180;
    localparam word_t D  = 32'h8000_01C0;
    localparam word_t T2 = 32'h8000_0200;
    localparam word_t T3 = 32'h8000_0300;
    localparam word_t T4 = 32'h8000_0400;
    localparam word_t T5 = 32'h8000_0500;
    localparam word_t T6 = 32'h8000_0600;
    localparam word_t TX = 32'h8000_0900;

    bpb_assoc #(
        .SETS(16), .WAYS(2), .PORTS(2), .TAG_W(10), .CTR_INIT(2'b10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .pc_predict     (pc_predict),
        .hit            (hit),
        .destpc_predict (destpc_predict),
        .pc_commit      (pc_commit),
        .wen            (wen),
        .destpc_commit  (destpc_commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, stl, w, tkn;
        word_t      pcc, dstc, pc0, pc1;
        logic [1:0] eh;
        word_t      ed0;
        logic       et0;
        word_t      ed1;
        logic       et1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stl, logic w, logic tkn, word_t pcc, word_t dstc,
                                word_t pc0, word_t pc1, logic [1:0] eh,
                                word_t ed0, logic et0, word_t ed1, logic et1);
        vec_t v;
        v.rst = rst; v.stl = stl; v.w = w; v.tkn = tkn;
        v.pcc = pcc; v.dstc = dstc; v.pc0 = pc0; v.pc1 = pc1;
        v.eh = eh; v.ed0 = ed0; v.et0 = et0; v.ed1 = ed1; v.et1 = et1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset                = v.rst;
        stall                = v.stl;
        wen                  = v.w;
        pc_commit            = v.pcc;
        destpc_commit.destpc = v.dstc;
        destpc_commit.taken  = v.tkn;
        pc_predict[0]        = v.pc0;
        pc_predict[1]        = v.pc1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input vec_t v);
        chk({name, ".hit"}, 64'(hit), 64'(v.eh));
        chk({name, ".p0"}, 64'({destpc_predict[0].destpc, destpc_predict[0].taken}), 64'({v.ed0, v.et0}));
        chk({name, ".p1"}, 64'({destpc_predict[1].destpc, destpc_predict[1].taken}), 64'({v.ed1, v.et1}));
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; stall = 1'b0; wen = 1'b0;
        pc_commit = '0; destpc_commit = '0; pc_predict = '0;

        // reset (with a discarded commit) and empty-buffer lookups
        vecs.push_back(mk(1,0,1,1, A, TX, A, A4, 2'b00, 0,0, 0,0));
        vecs.push_back(mk(1,0,0,0, 0, 0,  A, A4, 2'b00, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0, 0,  A, A4, 2'b00, 0,0, 0,0));
        // allocate A; same-edge lookup sees old contents
        vecs.push_back(mk(0,0,1,1, A, T2, A, A4, 2'b00, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0, 0,  A, A4, 2'b01, T2,1, 0,0));
        // counter down to 0 and saturation at 0
        vecs.push_back(mk(0,0,1,0, A, 0,  A, A4, 2'b01, T2,1, 0,0));
        vecs.push_back(mk(0,0,1,0, A, 0,  A, A4, 2'b01, T2,0, 0,0));
        vecs.push_back(mk(0,0,1,0, A, 0,  A, A4, 2'b01, T2,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0, 0,  A, A4, 2'b01, T2,0, 0,0));
        // counter up to 3 and saturation at 3, target retrained
        vecs.push_back(mk(0,0,1,1, A, T3, A, A4, 2'b01, T2,0, 0,0));
        vecs.push_back(mk(0,0,1,1, A, T3, A, A4, 2'b01, T3,0, 0,0));
        vecs.push_back(mk(0,0,1,1, A, T3, A, A4, 2'b01, T3,1, 0,0));
        vecs.push_back(mk(0,0,1,1, A, T3, A, A4, 2'b01, T3,1, 0,0));
        vecs.push_back(mk(0,0,1,0, A, 0,  A, A4, 2'b01, T3,1, 0,0));
        vecs.push_back(mk(0,0,1,0, A, 0,  A, A4, 2'b01, T3,1, 0,0));
        vecs.push_back(mk(0,0,0,0, 0, 0,  A, A4, 2'b01, T3,0, 0,0));
        // same-index conflicts: B fills way1, C evicts A, D evicts B
        vecs.push_back(mk(0,0,1,1, B, T4, B, A,  2'b10, 0,0, T3,0));
        vecs.push_back(mk(0,0,1,1, C, T5, A, B,  2'b11, T3,0, T4,1));
        vecs.push_back(mk(0,0,0,0, 0, 0,  A, C,  2'b10, 0,0, T5,1));
        vecs.push_back(mk(0,0,0,0, 0, 0,  B, B,  2'b11, T4,1, T4,1));
        vecs.push_back(mk(0,0,1,1, D, T6, C, B,  2'b11, T5,1, T4,1));
        vecs.push_back(mk(0,0,0,0, 0, 0,  B, D,  2'b10, 0,0, T6,1));
        vecs.push_back(mk(0,0,0,0, 0, 0,  C, A4, 2'b01, T5,1, 0,0));
        // not-taken miss allocates nothing
        vecs.push_back(mk(0,0,1,0, A4, T2, A4, C, 2'b10, 0,0, T5,1));
        vecs.push_back(mk(0,0,0,0, 0, 0,   A4, C, 2'b10, 0,0, T5,1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            expect_out($sformatf("v%0d", i), vecs[i]);
        end

        // stall freezes outputs while a commit still trains C
        v = mk(0,0,0,0, 0, 0, C, D, 2'b11, T5,1, T6,1);
        apply(v); expect_out("stall_pre", v);
        v = mk(0,1,1,0, C, 0, A4, B, 2'b11, T5,1, T6,1);
        apply(v); expect_out("stall_hold0", v);
        v = mk(0,1,0,0, 0, 0, C, C, 2'b11, T5,1, T6,1);
        apply(v); expect_out("stall_hold1", v);
        v = mk(0,0,0,0, 0, 0, C, D, 2'b11, T5,0, T6,1);
        apply(v); expect_out("stall_release", v);

        // reset wins over stall and discards the commit; fresh allocation uses CTR_INIT
        v = mk(1,1,1,1, A4, T2, C, D, 2'b00, 0,0, 0,0);
        apply(v); expect_out("rst_stall", v);
        v = mk(0,0,0,0, 0, 0, C, A4, 2'b00, 0,0, 0,0);
        apply(v); expect_out("post_rst", v);
        v = mk(0,0,1,1, A4, T2, A4, C, 2'b00, 0,0, 0,0);
        apply(v); expect_out("realloc_same", v);
        v = mk(0,0,0,0, 0, 0, A4, C, 2'b01, T2,1, 0,0);
        apply(v); expect_out("realloc_next", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
